// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo counter block.
package mod_counter_pkg;

    // Count direction encoding, sampled on the dir input
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : mod_counter_pkg

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones,
// cleared synchronously by clr or asynchronously by rst.
module sat_counter #(
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WRAPW-1:0] cnt,
    output logic             sat
);

    assign sat = &cnt;

    // Count inc events, hold once all-ones is reached; clr wins over inc
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !sat)
            cnt <= cnt + 1'b1;
    end

endmodule : sat_counter

// File: rtl/mod_counter.sv
// Up/down modulo-MODULUS counter with load, clear, one-hot phase decode,
// terminal-count strobe and a saturating count of wrap events.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 3,
    parameter int WRAPW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               dir,
    output logic [WIDTH-1:0]   count,
    output logic [MODULUS-1:0] phase,
    output logic               tc,
    output logic [WRAPW-1:0]   wrap_cnt,
    output logic               wrap_sat
);

    // Reject parameter sets where the count range does not fit the register
    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
            $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
    // One bit wider so MODULUS == 2**WIDTH is representable
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic             wrap_pt;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamp;

    // Next value for an enabled step, plus whether this step wraps
    always_comb begin
        if (dir == DIR_UP) begin
            wrap_pt  = (count == MAXV);
            step_val = wrap_pt ? '0 : count + 1'b1;
        end else begin
            wrap_pt  = (count == '0);
            step_val = wrap_pt ? MAXV : count - 1'b1;
        end
    end

    // Out-of-range loads clamp to the top of the range to keep phase one-hot
    assign load_clamp = ({1'b0, load_val} >= MOD_EXT) ? MAXV : load_val;

    // tc only fires for a real enabled step; reset, clr and load suppress it
    assign tc = rst && en && !clr && !load && wrap_pt;

    // Count register with priority clr > load > en
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_clamp;
        else if (en)
            count <= step_val;
    end

    // One-hot decode of the registered count
    always_comb begin
        phase = '0;
        for (int i = 0; i < MODULUS; i++)
            phase[i] = (count == WIDTH'(i));
    end

    sat_counter #(
        .WRAPW (WRAPW)
    ) u_wrap (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (tc),
        .cnt (wrap_cnt),
        .sat (wrap_sat)
    );

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: directed steps push expected results,
// a monitor compares tc before each edge and state after it.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b0;
    logic [1:0] load_val = '0;

    logic [1:0] count, count2;
    logic [2:0] phase, phase2;
    logic       tc, tc2;
    logic [7:0] wrap_cnt;
    logic       wrap_sat;
    logic [1:0] wrap_cnt2;
    logic       wrap_sat2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       tc;
        logic [1:0] count;
        logic [7:0] wrap;
        logic [1:0] wrap2;
        logic       sat2;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(2), .MODULUS(3), .WRAPW(8)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir), .count(count), .phase(phase),
        .tc(tc), .wrap_cnt(wrap_cnt), .wrap_sat(wrap_sat)
    );

    mod_counter #(.WIDTH(2), .MODULUS(3), .WRAPW(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir), .count(count2), .phase(phase2),
        .tc(tc2), .wrap_cnt(wrap_cnt2), .wrap_sat(wrap_sat2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one cycle of stimulus and queue its expected outcome
    task automatic step(input logic e, input logic c, input logic l, input logic [1:0] lv,
                        input logic d, input logic xtc, input logic [1:0] xcnt,
                        input logic [7:0] xw, input logic [1:0] xw2, input logic xs2);
        exp_t x;
        @(negedge clk);
        en = e; clr = c; load = l; load_val = lv; dir = d;
        x.tc = xtc; x.count = xcnt; x.wrap = xw; x.wrap2 = xw2; x.sat2 = xs2;
        sb.push_back(x);
    endtask

    // Return inputs to idle before the next edge, then wait for the monitor
    task automatic drain();
        int n = 0;
        @(negedge clk);
        en = 0; clr = 0; load = 0; dir = 0; load_val = '0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: tc just before the edge, registered state just after it
    initial begin
        exp_t e;
        logic [2:0] ph;
        forever begin
            @(negedge clk); #4;
            if (sb.size() != 0) begin
                e = sb[0];
                chk("tc", 32'(tc), 32'(e.tc));
                chk("tc2", 32'(tc2), 32'(e.tc));
                @(posedge clk); #1;
                ph = 3'b001 << e.count;
                chk("count", 32'(count), 32'(e.count));
                chk("phase", 32'(phase), 32'(ph));
                chk("wrap_cnt", 32'(wrap_cnt), 32'(e.wrap));
                chk("wrap_sat", 32'(wrap_sat), 32'(e.wrap == 8'hFF));
                chk("count2", 32'(count2), 32'(e.count));
                chk("wrap_cnt2", 32'(wrap_cnt2), 32'(e.wrap2));
                chk("wrap_sat2", 32'(wrap_sat2), 32'(e.sat2));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2;
        // Reset: en with dir down at count 0 would be a wrap point, tc must stay low
        rst = 0; en = 1; dir = 1;
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_phase", 32'(phase), 32'b001);
        chk("rst_wrap", 32'(wrap_cnt), 0);
        chk("rst_sat", 32'(wrap_sat), 0);
        chk("rst_tc", 32'(tc), 0);
        @(negedge clk);
        rst = 1; en = 0; dir = 0;

        // Count up 7 cycles
        step(1,0,0,0,0, 0,1,0,0,0);
        step(1,0,0,0,0, 0,2,0,0,0);
        step(1,0,0,0,0, 1,0,1,1,0);
        step(1,0,0,0,0, 0,1,1,1,0);
        step(1,0,0,0,0, 0,2,1,1,0);
        step(1,0,0,0,0, 1,0,2,2,0);
        step(1,0,0,0,0, 0,1,2,2,0);
        // clr alone
        step(0,1,0,0,0, 0,0,0,0,0);
        // Count down 4 cycles
        step(1,0,0,0,1, 1,2,1,1,0);
        step(1,0,0,0,1, 0,1,1,1,0);
        step(1,0,0,0,1, 0,0,1,1,0);
        step(1,0,0,0,1, 1,2,2,2,0);
        // Load beats en at a wrap point; out-of-range load clamps
        step(1,0,1,3,0, 0,2,2,2,0);
        step(0,0,1,1,0, 0,1,2,2,0);
        step(1,0,1,2,1, 0,2,2,2,0);
        // Idle holds
        step(0,0,0,0,0, 0,2,2,2,0);
        // clr beats load and en
        step(1,1,1,1,0, 0,0,0,0,0);
        // 15 up-steps: narrow wrap counter saturates at 3
        for (int k = 1; k <= 15; k++) begin
            w  = k / 3;
            w2 = (w > 3) ? 3 : w;
            step(1,0,0,0,0, (k % 3) == 0, 2'(k % 3), 8'(w), 2'(w2), w >= 3);
        end
        // Direction flips each cycle; wrap point follows current dir
        step(1,0,0,0,1, 1,2,6,3,1);
        step(1,0,0,0,0, 1,0,7,3,1);
        // Reach count=2, wrap_cnt=1
        step(0,1,0,0,0, 0,0,0,0,0);
        step(1,0,0,0,1, 1,2,1,1,0);
        drain();

        // Async reset between edges
        @(posedge clk); #2;
        rst = 0; en = 1; dir = 1;
        #1;
        chk("mid_count", 32'(count), 0);
        chk("mid_phase", 32'(phase), 32'b001);
        chk("mid_wrap", 32'(wrap_cnt), 0);
        chk("mid_sat", 32'(wrap_sat), 0);
        chk("mid_tc", 32'(tc), 0);
        chk("mid_wrap2", 32'(wrap_cnt2), 0);
        #1;
        rst = 1; en = 0; dir = 0;
        step(1,0,0,0,0, 0,1,0,0,0);
        step(1,0,0,0,0, 0,2,0,0,0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mod_counter

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 2, meaning count register width in bits.
REQ-002 SHALL have parameter MODULUS, default 3, meaning count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have parameter WRAPW, default 8, meaning width of the wrap-event counter.
REQ-004 SHALL have port clk, input, 1, meaning the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, meaning advance count one step this cycle.
REQ-007 SHALL have port clr, input, 1, meaning synchronous clear of count and wrap_cnt.
REQ-008 SHALL have port load, input, 1, meaning synchronous load of load_val into count.
REQ-009 SHALL have port load_val, input, WIDTH, meaning value to load.
REQ-010 SHALL have port dir, input, 1, meaning 0 = count up, 1 = count down.
REQ-011 SHALL have port count, output, WIDTH, meaning current registered count.
REQ-012 SHALL have port phase, output, MODULUS, meaning one-hot decode of count (bit[count] = 1).
REQ-013 SHALL have port tc, output, 1, meaning terminal count: combinational, high when en=1, clr=0, load=0 and count is at the wrap point for the current dir.
REQ-014 SHALL have port wrap_cnt, output, WRAPW, meaning number of wraps since reset or clr, saturating.
REQ-015 SHALL have port wrap_sat, output, 1, meaning wrap_cnt is all-ones.

Function
REQ-016 SHALL apply per-cycle priority clr > load > en; with none asserted, all state holds.
REQ-017 SHALL, on clr, set count=0 and wrap_cnt=0 at the next edge, regardless of load/en/dir.
REQ-018 SHALL, on load without clr, set count=load_val, or MODULUS-1 if load_val >= MODULUS; wrap_cnt unchanged.
REQ-019 SHALL, on en with dir=0, set count=count+1, except count==MODULUS-1 goes to 0.
REQ-020 SHALL, on en with dir=1, set count=count-1, except count==0 goes to MODULUS-1.
REQ-021 SHALL have single-cycle latency: count, phase and wrap_cnt reflect an action at the edge after it is sampled.
REQ-022 SHALL increment wrap_cnt on exactly those edges where tc=1, holding at 2**WRAPW-1 once reached.
REQ-023 SHALL allow dir to change on any cycle; the wrap point follows the dir sampled that cycle.
REQ-024 SHALL never drive count outside 0..MODULUS-1, so phase is always exactly one-hot.
REQ-025 SHALL, with MODULUS=3 and WIDTH=2, behave identically to the existing mod-3 phase counter when en=1, dir=0, clr=load=0.

Reset
REQ-026 SHALL, while rst=0, force count=0, wrap_cnt=0, phase=1 (bit 0), wrap_sat=0 asynchronously.
REQ-027 SHALL hold tc=0 while rst=0.
REQ-028 SHALL resume normal operation at the first rising clk edge after rst deasserts; a reset asserted mid-sequence discards all state.
REQ-029 SHALL rely on rst, not simulation initial statements, for its reset state.

Structure
REQ-030 SHALL place the direction constants DIR_UP=0 and DIR_DOWN=1 in shared package mod_counter_pkg.
REQ-031 SHALL implement wrap_cnt/wrap_sat in one sub-module sat_counter (params WRAPW; ports clk, rst, clr, inc, cnt, sat).
REQ-032 SHALL check the parameters at elaboration and raise an error if MODULUS < 2 or MODULUS > 2**WIDTH.

Verification
REQ-033 Scenario: reset, then en=1, dir=0 for 7 cycles -> count 1,2,0,1,2,0,1; tc high on cycles 3 and 6; wrap_cnt=2.
REQ-034 Scenario: reset, then en=1, dir=1 for 4 cycles -> count 2,1,0,2; tc high on cycle 1 (count 0->2) and cycle 4; phase 100,010,001,100.
REQ-035 Scenario: load=1, load_val=3 (MODULUS=3) -> count=2; same cycle with en=1 at count==2 -> no wrap_cnt change.
REQ-036 Scenario: clr=1, load=1, en=1 together at count=2 -> count=0, wrap_cnt=0, tc=0.
REQ-037 Scenario: WRAPW=2, en=1 for 15 cycles -> wrap_cnt saturates at 3, wrap_sat=1, count keeps cycling.
REQ-038 Scenario: rst pulsed low between clock edges at count=2, wrap_cnt=1 -> outputs go to 0/0/phase=001 immediately; counting restarts from 0 at the next edge.
